// File: rtl/fridge_ctrl_multi_if.sv
// Register write port between the control panel decoder and the fridge controller.
// The master drives the write strobe and fields; the slave answers with wr_err.
interface fridge_ctrl_multi_if #(
    parameter int CW = 1,
    parameter int DW = 5
);
    logic          wr_en;
    logic [1:0]    sel_field;
    logic [CW-1:0] sel_comp;
    logic [DW-1:0] wr_data;
    logic          wr_err;

    modport master (output wr_en, sel_field, sel_comp, wr_data, input wr_err);
    modport slave  (input wr_en, sel_field, sel_comp, wr_data, output wr_err);
endinterface

// File: rtl/fridge_ctrl_multi.sv
// N-compartment fridge/freezer controller: per-compartment register file plus one
// hysteresis thermostat FSM per compartment with a compressor minimum-off lockout.
//
// state | meaning
// OFF   | compartment unpowered or disabled, compressor off
// LOCK  | compressor minimum-off lockout, counting down
// IDLE  | lockout served, waiting for temperature above hi threshold
// COOL  | compressor running until temperature at or below lo threshold
module fridge_ctrl_multi #(
    parameter int N_COMP  = 2,
    parameter int DW      = 5,
    parameter int HYST    = 1,
    parameter int MIN_OFF = 8,
    parameter int DEF_SET = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   pwr_i,
    fridge_ctrl_multi_if.slave     wr_if,
    input  logic [N_COMP*DW-1:0]   sens_temp_i,
    output logic [N_COMP*DW-1:0]   setpoint_o,
    output logic [N_COMP*DW-1:0]   capacity_o,
    output logic [N_COMP-1:0]      comp_en_o,
    output logic [N_COMP-1:0]      cool_on_o
);
    localparam int CNTW = $clog2(MIN_OFF + 1);

    typedef enum logic [1:0] {
        S_OFF  = 2'd0,
        S_LOCK = 2'd1,
        S_IDLE = 2'd2,
        S_COOL = 2'd3
    } state_t;

    logic [DW-1:0]     sp_q  [N_COMP];
    logic [DW-1:0]     sp_d  [N_COMP];
    logic [DW-1:0]     cap_q [N_COMP];
    logic [DW-1:0]     cap_d [N_COMP];
    logic [N_COMP-1:0] en_q, en_d;
    logic              wr_err_q, wr_err_d;
    logic              wr_acc;

    always_comb begin
        sp_d     = sp_q;
        cap_d    = cap_q;
        en_d     = en_q;
        wr_acc   = wr_if.wr_en && pwr_i && (wr_if.sel_field != 2'd3)
                   && (int'(wr_if.sel_comp) < N_COMP);
        wr_err_d = wr_if.wr_en && !wr_acc;
        if (wr_acc) begin
            for (int k = 0; k < N_COMP; k++) begin
                if (int'(wr_if.sel_comp) == k) begin
                    case (wr_if.sel_field)
                        2'd0:    sp_d[k]  = wr_if.wr_data;
                        2'd1:    cap_d[k] = wr_if.wr_data;
                        2'd2:    en_d[k]  = wr_if.wr_data[0];
                        default: ;
                    endcase
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < N_COMP; k++) begin
                sp_q[k]  <= DW'(DEF_SET);
                cap_q[k] <= '0;
            end
            en_q     <= '0;
            wr_err_q <= 1'b0;
        end else begin
            sp_q     <= sp_d;
            cap_q    <= cap_d;
            en_q     <= en_d;
            wr_err_q <= wr_err_d;
        end
    end

    assign wr_if.wr_err = wr_err_q;
    assign comp_en_o    = en_q;

    for (genvar k = 0; k < N_COMP; k++) begin : g_comp
        state_t          state_q, state_d;
        logic [CNTW-1:0] cnt_q, cnt_d;
        logic [DW:0]     temp_x, hi, lo;

        assign setpoint_o[k*DW +: DW] = sp_q[k];
        assign capacity_o[k*DW +: DW] = cap_q[k];
        assign cool_on_o[k]           = (state_q == S_COOL);

        // Thresholds carry an extra bit so hi never wraps and lo saturates at zero.
        always_comb begin
            temp_x = {1'b0, sens_temp_i[k*DW +: DW]};
            hi     = {1'b0, sp_q[k]} + (DW+1)'(HYST);
            if ({1'b0, sp_q[k]} >= (DW+1)'(HYST)) lo = {1'b0, sp_q[k]} - (DW+1)'(HYST);
            else                                  lo = '0;
        end

        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            if (!pwr_i || !en_q[k]) begin
                state_d = S_OFF;
                cnt_d   = '0;
            end else begin
                case (state_q)
                    S_OFF: begin
                        state_d = S_LOCK;
                        cnt_d   = CNTW'(MIN_OFF);
                    end
                    S_LOCK: begin
                        cnt_d = cnt_q - CNTW'(1);
                        if (cnt_q == CNTW'(1)) state_d = S_IDLE;
                    end
                    S_IDLE: begin
                        if (temp_x > hi) state_d = S_COOL;
                    end
                    S_COOL: begin
                        if (temp_x <= lo) begin
                            state_d = S_LOCK;
                            cnt_d   = CNTW'(MIN_OFF);
                        end
                    end
                    default: state_d = S_OFF;
                endcase
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state_q <= S_OFF;
                cnt_q   <= '0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
            end
        end
    end
endmodule

// File: tb/tb_fridge_ctrl_multi.sv
// Bench for fridge_ctrl_multi: directed scenarios then random traffic, compared
// every cycle against a timestamp-based model of the thermostat rules.
module tb_fridge_ctrl_multi;
    localparam int N       = 2;
    localparam int DW      = 5;
    localparam int HYST    = 1;
    localparam int MIN_OFF = 8;
    localparam int DEF_SET = 4;
    localparam int CW      = 1;

    logic            clk;
    logic            rst_n;
    logic            pwr;
    logic [N*DW-1:0] sens;
    logic [N*DW-1:0] setpoint;
    logic [N*DW-1:0] capacity;
    logic [N-1:0]    comp_en;
    logic [N-1:0]    cool_on;

    fridge_ctrl_multi_if #(.CW(CW), .DW(DW)) wr_if ();

    fridge_ctrl_multi #(
        .N_COMP(N), .DW(DW), .HYST(HYST), .MIN_OFF(MIN_OFF), .DEF_SET(DEF_SET)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .pwr_i       (pwr),
        .wr_if       (wr_if.slave),
        .sens_temp_i (sens),
        .setpoint_o  (setpoint),
        .capacity_o  (capacity),
        .comp_en_o   (comp_en),
        .cool_on_o   (cool_on)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_mis = 0;

    // Model: a compartment may start cooling only on an edge strictly after its
    // ready time, which is MIN_OFF edges after it was enabled or stopped cooling.
    int m_sp [N];
    int m_cap [N];
    bit m_en [N];
    bit m_active [N];
    bit m_cooling [N];
    int m_ready [N];
    bit m_err;
    int cyc;

    task automatic model_reset();
        for (int k = 0; k < N; k++) begin
            m_sp[k] = DEF_SET; m_cap[k] = 0; m_en[k] = 0;
            m_active[k] = 0; m_cooling[k] = 0; m_ready[k] = 0;
        end
        m_err = 0;
        cyc = 0;
    endtask

    task automatic model_edge();
        int t, hi, lo, c;
        bit acc;
        cyc++;
        for (int k = 0; k < N; k++) begin
            t  = int'(sens[k*DW +: DW]);
            hi = m_sp[k] + HYST;
            lo = (m_sp[k] > HYST) ? m_sp[k] - HYST : 0;
            if (!(pwr && m_en[k])) begin
                m_active[k] = 0; m_cooling[k] = 0;
            end else if (!m_active[k]) begin
                m_active[k] = 1; m_cooling[k] = 0; m_ready[k] = cyc + MIN_OFF;
            end else if (m_cooling[k]) begin
                if (t <= lo) begin m_cooling[k] = 0; m_ready[k] = cyc + MIN_OFF; end
            end else if (cyc > m_ready[k] && t > hi) begin
                m_cooling[k] = 1;
            end
        end
        c   = int'(wr_if.sel_comp);
        acc = wr_if.wr_en && pwr && (wr_if.sel_field != 2'd3) && (c < N);
        m_err = wr_if.wr_en && !acc;
        if (acc) begin
            case (wr_if.sel_field)
                2'd0: m_sp[c]  = int'(wr_if.wr_data);
                2'd1: m_cap[c] = int'(wr_if.wr_data);
                2'd2: m_en[c]  = wr_if.wr_data[0];
                default: ;
            endcase
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed=%0h expected=%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all();
        logic [N*DW-1:0] e_sp, e_cap;
        logic [N-1:0]    e_en, e_cool;
        for (int k = 0; k < N; k++) begin
            e_sp[k*DW +: DW]  = DW'(m_sp[k]);
            e_cap[k*DW +: DW] = DW'(m_cap[k]);
            e_en[k]           = m_en[k];
            e_cool[k]         = m_cooling[k];
        end
        chk("cool_on",  32'(cool_on),      32'(e_cool));
        chk("comp_en",  32'(comp_en),      32'(e_en));
        chk("setpoint", 32'(setpoint),     32'(e_sp));
        chk("capacity", 32'(capacity),     32'(e_cap));
        chk("wr_err",   32'(wr_if.wr_err), 32'(m_err));
    endtask

    task automatic step(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            model_edge();
            #1;
            check_all();
        end
    endtask

    task automatic wr(input logic [1:0] f, input logic [CW-1:0] c, input logic [DW-1:0] d);
        wr_if.wr_en = 1'b1; wr_if.sel_field = f; wr_if.sel_comp = c; wr_if.wr_data = d;
        step();
        wr_if.wr_en = 1'b0;
    endtask

    task automatic set_sens(input int k, input int v);
        sens[k*DW +: DW] = DW'(v);
    endtask

    initial begin
        rst_n = 1'b0; pwr = 1'b1; sens = '0;
        wr_if.wr_en = 1'b0; wr_if.sel_field = '0; wr_if.sel_comp = '0; wr_if.wr_data = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_setpoint", 32'(setpoint), 32'({DW'(4), DW'(4)}));
        chk("rst_cool",     32'(cool_on),  32'h0);
        chk("rst_en",       32'(comp_en),  32'h0);
        chk("rst_cap",      32'(capacity), 32'h0);
        chk("rst_err",      32'(wr_if.wr_err), 32'h0);
        rst_n = 1'b1;

        // Lockout, cooling, cool-down and re-lockout on the freezer.
        wr(2'd0, 1'b1, 5'd10);
        set_sens(1, 12);
        wr(2'd2, 1'b1, 5'd1);
        step(12);
        set_sens(1, 9);
        step(3);
        set_sens(1, 12);
        step(12);

        // Setpoint 0: lo saturates at 0.
        wr(2'd0, 1'b0, 5'd0);
        set_sens(0, 2);
        wr(2'd2, 1'b0, 5'd1);
        step(12);
        set_sens(0, 1);
        step(3);
        set_sens(0, 0);
        step(3);

        // Setpoint 31: hi=32, so even the maximum reading never cools.
        wr(2'd0, 1'b0, 5'd31);
        set_sens(0, 31);
        step(14);

        // Setpoint change during COOL and simultaneous crossing.
        set_sens(1, 20);
        step(2);
        wr(2'd0, 1'b1, 5'd25);
        step(2);
        wr(2'd0, 1'b1, 5'd10);
        step(12);

        // Rejected writes and capacity storage.
        wr(2'd3, 1'b0, 5'd7);
        step();
        pwr = 1'b0;
        wr(2'd1, 1'b0, 5'd9);
        pwr = 1'b1;
        step(2);
        wr(2'd1, 1'b0, 5'd17);
        step();

        // comp_en cleared while cooling.
        wr(2'd2, 1'b1, 5'd0);
        step(2);
        wr(2'd2, 1'b1, 5'd1);

        // Power drop with both compartments cooling, then full lockout on return.
        wr(2'd0, 1'b0, 5'd10);
        set_sens(0, 20);
        set_sens(1, 20);
        step(14);
        chk("both_cool", 32'(cool_on), 32'h3);
        pwr = 1'b0;
        step(3);
        pwr = 1'b1;
        step(14);

        // Asynchronous reset mid-COOL.
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_cool",     32'(cool_on),  32'h0);
        chk("arst_setpoint", 32'(setpoint), 32'({DW'(4), DW'(4)}));
        chk("arst_err",      32'(wr_if.wr_err), 32'h0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step();

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 39) == 0) pwr = ~pwr;
            if (i % 6 == 0) begin
                for (int k = 0; k < N; k++) set_sens(k, int'($urandom_range(0, 31)));
            end
            if ($urandom_range(0, 3) == 0) begin
                wr_if.wr_en     = 1'b1;
                wr_if.sel_field = 2'($urandom_range(0, 3));
                wr_if.sel_comp  = CW'($urandom_range(0, N - 1));
                wr_if.wr_data   = DW'($urandom_range(0, 31));
                if (wr_if.sel_field == 2'd2 && $urandom_range(0, 3) != 0) wr_if.wr_data[0] = 1'b1;
            end else begin
                wr_if.wr_en = 1'b0;
            end
            step();
        end
        wr_if.wr_en = 1'b0;
        step(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
